// File: rtl/alu_decode_if.sv
// alu_decode_if: fetch-side and execute-side bus of the ALU decode stage.
//   Fetch side : in_valid/in_ready handshake, in_instr, in_pc, plus flush.
//   Execute side: out_valid/out_ready handshake, out_pc, alu_op, a_sel, b_sel,
//                 imm, rd/rs1/rs2 and the class flags.
// master = surrounding pipeline (fetch + execute), slave = the decode stage.
interface alu_decode_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  alu_op;
  logic [1:0]  a_sel;
  logic        b_sel;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        reg_write;
  logic        is_branch;
  logic        is_load;
  logic        is_store;
  logic        is_jump;
  logic        illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm, rd, rs1, rs2,
           reg_write, is_branch, is_load, is_store, is_jump, illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, alu_op, a_sel, b_sel, imm, rd, rs1, rs2,
           reg_write, is_branch, is_load, is_store, is_jump, illegal
  );
endinterface

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: one-slice pipelined RV32I/M decode into ALU op code,
// operand selects, sign-extended immediate, register indices and class flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (wins over flush)
//   bus  - alu_decode_if.slave: fetch handshake in, decoded word out, flush
// Encodings the ALU cannot execute (SRL/SRLI, DIVU/REMU, MULH*, ...) decode
// as illegal with every control zeroed except illegal=1.
module alu_decode_stage (
  input  logic         clk,
  input  logic         rst,
  alu_decode_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRA = 4'd6,  OP_SLT = 4'd7;
  localparam logic [3:0] OP_EQ  = 4'd8,  OP_NE  = 4'd9,  OP_GE  = 4'd10, OP_LTU = 4'd11;
  localparam logic [3:0] OP_GEU = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_REM = 4'd15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        reg_write;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        is_jump;
    logic        illegal;
  } dec_t;

  dec_t        dec_d, dec_q;
  logic        valid_q;
  logic        accept;
  logic        ok;
  logic [31:0] w;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  // Shared f3 mapping of OP / OP-IMM base ops; {legal, op}. f3=5 is handled
  // by the caller because only the arithmetic shift exists.
  function automatic logic [4:0] base_op(input logic [2:0] f);
    case (f)
      3'd0:    base_op = {1'b1, OP_ADD};
      3'd1:    base_op = {1'b1, OP_SLL};
      3'd2:    base_op = {1'b1, OP_SLT};
      3'd3:    base_op = {1'b1, OP_LTU};
      3'd4:    base_op = {1'b1, OP_XOR};
      3'd6:    base_op = {1'b1, OP_OR};
      3'd7:    base_op = {1'b1, OP_AND};
      default: base_op = {1'b0, OP_ADD};
    endcase
  endfunction

  assign w     = bus.in_instr;
  assign opc   = w[6:0];
  assign f3    = w[14:12];
  assign f7    = w[31:25];
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  always_comb begin
    dec_d = '0;
    ok    = 1'b1;
    case (opc)
      7'b0110011: begin // OP
        dec_d.reg_write = 1'b1;
        case (f7)
          7'h00: {ok, dec_d.alu_op} = base_op(f3);
          7'h20: begin
            if (f3 == 3'd0)      dec_d.alu_op = OP_SUB;
            else if (f3 == 3'd5) dec_d.alu_op = OP_SRA;
            else                 ok = 1'b0;
          end
          7'h01: begin
            case (f3)
              3'd0:    dec_d.alu_op = OP_MUL;
              3'd4:    dec_d.alu_op = OP_DIV;
              3'd6:    dec_d.alu_op = OP_REM;
              default: ok = 1'b0;
            endcase
          end
          default: ok = 1'b0;
        endcase
      end
      7'b0010011: begin // OP-IMM; shift amounts live in imm[4:0], imm[11:5] is funct7
        dec_d.reg_write = 1'b1;
        dec_d.b_sel     = 1'b1;
        dec_d.imm       = imm_i;
        if (f3 == 3'd1) begin
          dec_d.alu_op = OP_SLL;
          ok           = (f7 == 7'h00);
        end else if (f3 == 3'd5) begin
          dec_d.alu_op = OP_SRA;
          ok           = (f7 == 7'h20);
        end else begin
          {ok, dec_d.alu_op} = base_op(f3);
        end
      end
      7'b1100011: begin // BRANCH
        dec_d.is_branch = 1'b1;
        dec_d.imm       = imm_b;
        case (f3)
          3'd0:    dec_d.alu_op = OP_EQ;
          3'd1:    dec_d.alu_op = OP_NE;
          3'd4:    dec_d.alu_op = OP_SLT;
          3'd5:    dec_d.alu_op = OP_GE;
          3'd6:    dec_d.alu_op = OP_LTU;
          3'd7:    dec_d.alu_op = OP_GEU;
          default: ok = 1'b0;
        endcase
      end
      7'b0000011: begin // LOAD
        dec_d.b_sel = 1'b1;  dec_d.imm = imm_i;
        dec_d.is_load = 1'b1; dec_d.reg_write = 1'b1;
      end
      7'b0100011: begin // STORE
        dec_d.b_sel = 1'b1;  dec_d.imm = imm_s;
        dec_d.is_store = 1'b1;
      end
      7'b0110111: begin // LUI: zero + imm
        dec_d.a_sel = 2'd2;  dec_d.b_sel = 1'b1;
        dec_d.imm = imm_u;   dec_d.reg_write = 1'b1;
      end
      7'b0010111: begin // AUIPC
        dec_d.a_sel = 2'd1;  dec_d.b_sel = 1'b1;
        dec_d.imm = imm_u;   dec_d.reg_write = 1'b1;
      end
      7'b1101111: begin // JAL
        dec_d.a_sel = 2'd1;  dec_d.b_sel = 1'b1;  dec_d.imm = imm_j;
        dec_d.is_jump = 1'b1; dec_d.reg_write = 1'b1;
      end
      7'b1100111: begin // JALR
        dec_d.b_sel = 1'b1;  dec_d.imm = imm_i;
        dec_d.is_jump = 1'b1; dec_d.reg_write = 1'b1;
        ok = (f3 == 3'd0);
      end
      default: ok = 1'b0; // also covers in_instr[1:0] != 2'b11
    endcase
    if (!ok) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
    // pc and indices pass through for every format, legal or not
    dec_d.pc  = bus.in_pc;
    dec_d.rd  = w[11:7];
    dec_d.rs1 = w[19:15];
    dec_d.rs2 = w[24:20];
  end

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush drops only the valid bit; held fields stay until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_pc    = dec_q.pc;
  assign bus.alu_op    = dec_q.alu_op;
  assign bus.a_sel     = dec_q.a_sel;
  assign bus.b_sel     = dec_q.b_sel;
  assign bus.imm       = dec_q.imm;
  assign bus.rd        = dec_q.rd;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.reg_write = dec_q.reg_write;
  assign bus.is_branch = dec_q.is_branch;
  assign bus.is_load   = dec_q.is_load;
  assign bus.is_store  = dec_q.is_store;
  assign bus.is_jump   = dec_q.is_jump;
  assign bus.illegal   = dec_q.illegal;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed cases plus randomized
// traffic against a cycle-level reference model of the stage.
module tb_alu_decode_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_decode_if bus ();
  alu_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm;
    logic        rw, br, ld, st, jmp, ill;
  } exp_t;

  // op code per funct3 for each family, -1 = no such ALU operation
  int base_tbl[8] = '{0, 5, 7, 11, 4, -1, 3, 2};
  int mext_tbl[8] = '{13, -1, -1, -1, 14, -1, 15, -1};
  int br_tbl[8]   = '{8, 9, -1, -1, 7, 10, 11, 12};

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t e;
    int op, iv, sv, bv, uv, jv;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    iv = int'(w[30:20]) - (w[31] ? 2048 : 0);
    sv = int'({w[30:25], w[11:7]}) - (w[31] ? 2048 : 0);
    bv = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
    uv = int'(w[31:12]) * 4096;
    jv = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
    e  = '0;
    op = 0;
    case (w[6:0])
      7'h33: begin
        e.rw = 1;
        if (f7 == 7'h00)      op = base_tbl[f3];
        else if (f7 == 7'h20) op = (f3 == 0) ? 1 : (f3 == 5) ? 6 : -1;
        else if (f7 == 7'h01) op = mext_tbl[f3];
        else                  op = -1;
      end
      7'h13: begin
        e.rw = 1; e.bsel = 1; e.imm = iv;
        if (f3 == 1)      op = (f7 == 7'h00) ? 5 : -1;
        else if (f3 == 5) op = (f7 == 7'h20) ? 6 : -1;
        else              op = base_tbl[f3];
      end
      7'h63: begin e.br = 1; e.imm = bv; op = br_tbl[f3]; end
      7'h03: begin e.ld = 1; e.rw = 1; e.bsel = 1; e.imm = iv; end
      7'h23: begin e.st = 1; e.bsel = 1; e.imm = sv; end
      7'h37: begin e.asel = 2; e.bsel = 1; e.imm = uv; e.rw = 1; end
      7'h17: begin e.asel = 1; e.bsel = 1; e.imm = uv; e.rw = 1; end
      7'h6F: begin e.asel = 1; e.bsel = 1; e.imm = jv; e.rw = 1; e.jmp = 1; end
      7'h67: begin e.bsel = 1; e.imm = iv; e.rw = 1; e.jmp = 1; op = (f3 == 0) ? 0 : -1; end
      default: op = -1;
    endcase
    if (op < 0) begin
      e     = '0;
      e.ill = 1;
    end else begin
      e.op = op[3:0];
    end
    return e;
  endfunction

  // reference state of the output slice
  logic        m_valid;
  exp_t        m_dec;
  logic [31:0] m_pc, m_instr;

  task automatic model_edge();
    logic rdy;
    if (rst) begin
      m_valid = 0; m_dec = '0; m_pc = 0; m_instr = 0;
    end else begin
      rdy = !m_valid || bus.out_ready;
      if (bus.flush) m_valid = 0;
      else if (bus.in_valid && rdy) begin
        m_valid = 1; m_dec = ref_dec(bus.in_instr); m_pc = bus.in_pc; m_instr = bus.in_instr;
      end else if (bus.out_ready) m_valid = 0;
    end
  endtask

  task automatic check_model();
    chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, (!m_valid || bus.out_ready)});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("out_pc",    bus.out_pc, m_pc);
    chk("alu_op",    {28'd0, bus.alu_op}, {28'd0, m_dec.op});
    chk("a_sel",     {30'd0, bus.a_sel},  {30'd0, m_dec.asel});
    chk("b_sel",     {31'd0, bus.b_sel},  {31'd0, m_dec.bsel});
    chk("imm",       bus.imm, m_dec.imm);
    chk("regs",      {17'd0, bus.rd, bus.rs1, bus.rs2}, {17'd0, m_instr[11:7], m_instr[19:15], m_instr[24:20]});
    chk("flags",     {26'd0, bus.reg_write, bus.is_branch, bus.is_load, bus.is_store, bus.is_jump, bus.illegal},
                     {26'd0, m_dec.rw, m_dec.br, m_dec.ld, m_dec.st, m_dec.jmp, m_dec.ill});
  endtask

  // one clock: compare on the falling edge, advance model on the rising edge
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy; bus.flush = fl;
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] op, input logic bsel,
                         input logic rw, input logic ill, input logic [31:0] imm);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_op"},    {28'd0, bus.alu_op}, {28'd0, op});
    chk({tag, "_bsel"},  {31'd0, bus.b_sel}, {31'd0, bsel});
    chk({tag, "_rw"},    {31'd0, bus.reg_write}, {31'd0, rw});
    chk({tag, "_ill"},   {31'd0, bus.illegal}, {31'd0, ill});
    chk({tag, "_imm"},   bus.imm, imm);
  endtask

  logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};
  logic [6:0] f7s[4]  = '{7'h00, 7'h20, 7'h01, 7'h7F};

  initial begin
    logic [31:0] w;
    rst = 1;
    drive(0, 0, 0, 1, 0);
    m_valid = 0; m_dec = '0; m_pc = 0; m_instr = 0;
    @(posedge clk); model_edge(); #1;
    @(posedge clk); model_edge(); #1;
    rst = 0;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_pc",    bus.out_pc, 32'd0);
    chk("rst_imm",   bus.imm, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // back-to-back basic decodes
    drive(1, 32'h002081B3, 32'h100, 1, 0); tick();
    chk_dec("add", 0, 0, 1, 0, 0);
    chk("add_regs", {17'd0, bus.rd, bus.rs1, bus.rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
    drive(1, 32'h402081B3, 32'h104, 1, 0); tick(); chk_dec("sub", 1, 0, 1, 0, 0);
    drive(1, 32'h027302B3, 32'h108, 1, 0); tick(); chk_dec("mul", 13, 0, 1, 0, 0);
    drive(1, 32'hFFF00093, 32'h10C, 1, 0); tick(); chk_dec("addi", 0, 1, 1, 0, 32'hFFFFFFFF);
    drive(1, 32'h0020F463, 32'h110, 1, 0); tick(); chk_dec("bgeu", 12, 0, 0, 0, 32'h8);
    chk("bgeu_br", {31'd0, bus.is_branch}, 32'd1);
    drive(1, 32'h0020D1B3, 32'h114, 1, 0); tick(); chk_dec("srl", 0, 0, 0, 1, 0);
    drive(1, 32'h00000000, 32'h118, 1, 0); tick(); chk_dec("zero", 0, 0, 0, 1, 0);
    drive(1, 32'h0220F1B3, 32'h11C, 1, 0); tick(); chk_dec("remu", 0, 0, 0, 1, 0);

    // backpressure: ADD held, ADDI pending
    drive(1, 32'h002081B3, 32'h200, 1, 0); tick();
    drive(1, 32'hFFF00093, 32'h204, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_pc",    bus.out_pc, 32'h200);
      chk_dec("bp_hold", 0, 0, 1, 0, 0);
    end
    bus.out_ready = 1; #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("bp_next_pc", bus.out_pc, 32'h204);
    chk_dec("bp_next", 0, 1, 1, 0, 32'hFFFFFFFF);

    // flush with a held word and a word being accepted
    drive(1, 32'h402081B3, 32'h300, 1, 1); tick();
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(1, 32'h027302B3, 32'h304, 1, 0); tick();
    chk("post_flush_pc", bus.out_pc, 32'h304);
    chk_dec("post_flush", 13, 0, 1, 0, 0);

    // reset mid-stream, together with flush and a new word
    drive(1, 32'hFFF00093, 32'h308, 1, 1); rst = 1; tick(); rst = 0;
    chk("mrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mrst_pc",    bus.out_pc, 32'd0);
    chk("mrst_imm",   bus.imm, 32'd0);
    chk("mrst_op",    {28'd0, bus.alu_op}, 32'd0);
    chk("mrst_rd",    {27'd0, bus.rd}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        w[6:0]   = opcs[$urandom_range(0, 8)];
        w[31:25] = f7s[$urandom_range(0, 3)];
      end
      drive($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 127) == 0);
      tick();
    end
    rst = 0;
    drive(0, 0, 0, 1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
